// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, flag indices and saturation helpers for alu_multicycle
// Contents:
//   alu_op_e     4-bit opcode encoding (11..15 unused / illegal)
//   alu_state_e  execute FSM state (IDLE, MUL_RUN)
//   FLAG_Z/V/N   bit positions inside the {Z, V, N} flag register
//   sat_max/min  two's-complement saturation bounds for a w-bit signed value,
//                returned in the low w bits of a 64-bit word
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_XOR    = 4'd2,
        OP_RED    = 4'd3,
        OP_SLL    = 4'd4,
        OP_SRA    = 4'd5,
        OP_ROR    = 4'd6,
        OP_PADDSB = 4'd7,
        OP_LLB    = 4'd8,
        OP_LHB    = 4'd9,
        OP_MUL    = 4'd10
    } alu_op_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } alu_state_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative signed multiplier (magnitude shift-add, sign fixed at the end)
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (aborts a multiply in flight)
//   start_i     load operands; the first partial product is added on this same edge
//   a_i, b_i    signed WIDTH-bit operands, sampled only when start_i is high
//   done_o      one-cycle pulse, high in the cycle after the last of WIDTH iterations
//   prod_o      full 2*WIDTH-bit signed product, valid while done_o is high
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   prod_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;
    logic               neg_q;
    logic               done_q;

    // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
    assign a_mag = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag = b_i[WIDTH-1] ? -b_i : b_i;

    // Iteration 1 happens on the start edge so that WIDTH iterations finish
    // one edge before the owner writes its result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                acc_q    <= b_mag[0] ? {{WIDTH{1'b0}}, a_mag} : '0;
                mcand_q  <= {{(WIDTH-1){1'b0}}, a_mag, 1'b0};
                mplier_q <= {1'b0, b_mag[WIDTH-1:1]};
                cnt_q    <= CW'(1);
                run_q    <= 1'b1;
                neg_q    <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            end else if (run_q) begin
                acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign prod_o = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - EX-stage ALU with registered result, Z/V/N flag register and optional iterative MUL
// Configuration macro: ALU_MUL_EN (defined: MUL via alu_mul_iter; undefined: opcode 10 is illegal)
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_ready  operation handshake; accepted when both high at a rising edge
//   op                  opcode (alu_pkg::alu_op_e)
//   src1, src2          operands (src1 also immediate / shift amount, src2 also shift data)
//   out_valid           one-cycle pulse marking result/flags for the completed op
//   result              registered result
//   flags               flag register {Z, V, N}, always reflects the last completed op
//   busy                multiply in progress (inverse of in_ready)
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int HW  = WIDTH / 2;

    localparam logic [63:0]      MAX_W = sat_max(WIDTH);
    localparam logic [63:0]      MIN_W = sat_min(WIDTH);
    localparam logic [63:0]      MAX_L = sat_max(LANE);
    localparam logic [63:0]      MIN_L = sat_min(LANE);
    localparam logic [WIDTH-1:0] SMAX  = MAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SMIN  = MIN_W[WIDTH-1:0];
    localparam logic [LANE-1:0]  LMAX  = MAX_L[LANE-1:0];
    localparam logic [LANE-1:0]  LMIN  = MIN_L[LANE-1:0];

    alu_op_e    op_e;
    alu_state_e state_q, state_d;

    logic [WIDTH-1:0]   result_q, result_d;
    logic [2:0]         flags_q, flags_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               is_mul_op;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_fits;
    logic [WIDTH-1:0]   mul_res;

    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [WIDTH-1:0]   red_sum;
    logic [WIDTH-1:0]   padd_res;
    logic [LANE:0]      lane_sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_v;
    logic               upd_zvn;
    logic               upd_z;

    assign op_e   = alu_op_e'(op);
    assign shamt  = src1[SHW-1:0];
    assign accept = in_valid & in_ready;

`ifdef ALU_MUL_EN
    assign is_mul_op = (op_e == OP_MUL);
    assign in_ready  = (state_q == ST_IDLE);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept & is_mul_op),
        .a_i     (src1),
        .b_i     (src2),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );
`else
    assign is_mul_op = 1'b0;
    assign in_ready  = 1'b1;
    assign mul_done  = 1'b0;
    assign mul_prod  = '0;
`endif

    // The product fits in signed WIDTH when its top WIDTH+1 bits are all equal.
    assign mul_fits = (&mul_prod[2*WIDTH-1:WIDTH-1]) | ~(|mul_prod[2*WIDTH-1:WIDTH-1]);
    assign mul_res  = mul_fits ? mul_prod[WIDTH-1:0] : (mul_prod[2*WIDTH-1] ? SMIN : SMAX);

    // Single-cycle datapaths. Sums are one bit wider than the operands; a
    // disagreement between the top two bits is signed overflow.
    always_comb begin
        add_sum  = {src1[WIDTH-1], src1} + {src2[WIDTH-1], src2};
        sub_diff = {src1[WIDTH-1], src1} - {src2[WIDTH-1], src2};
        // Four signed halves need only HW+2 bits, so WIDTH-bit arithmetic is exact.
        red_sum  = {{HW{src1[WIDTH-1]}}, src1[WIDTH-1:HW]} + {{HW{src1[HW-1]}}, src1[HW-1:0]}
                 + {{HW{src2[WIDTH-1]}}, src2[WIDTH-1:HW]} + {{HW{src2[HW-1]}}, src2[HW-1:0]};

        padd_res = '0;
        lane_sum = '0;
        for (int i = 0; i < WIDTH / LANE; i++) begin
            lane_sum = {src1[i*LANE+LANE-1], src1[i*LANE +: LANE]}
                     + {src2[i*LANE+LANE-1], src2[i*LANE +: LANE]};
            if (lane_sum[LANE] != lane_sum[LANE-1]) begin
                padd_res[i*LANE +: LANE] = lane_sum[LANE] ? LMIN : LMAX;
            end else begin
                padd_res[i*LANE +: LANE] = lane_sum[LANE-1:0];
            end
        end

        alu_res = '0;
        alu_v   = 1'b0;
        upd_zvn = 1'b0;
        upd_z   = 1'b0;
        case (op_e)
            OP_ADD: begin
                alu_v   = add_sum[WIDTH] ^ add_sum[WIDTH-1];
                alu_res = alu_v ? (add_sum[WIDTH] ? SMIN : SMAX) : add_sum[WIDTH-1:0];
                upd_zvn = 1'b1;
            end
            OP_SUB: begin
                alu_v   = sub_diff[WIDTH] ^ sub_diff[WIDTH-1];
                alu_res = alu_v ? (sub_diff[WIDTH] ? SMIN : SMAX) : sub_diff[WIDTH-1:0];
                upd_zvn = 1'b1;
            end
            OP_XOR: begin
                alu_res = src1 ^ src2;
                upd_z   = 1'b1;
            end
            OP_RED:    alu_res = red_sum;
            OP_SLL: begin
                alu_res = src2 << shamt;
                upd_z   = 1'b1;
            end
            OP_SRA: begin
                alu_res = $signed(src2) >>> shamt;
                upd_z   = 1'b1;
            end
            OP_ROR: begin
                // A zero amount shifts the left term out entirely, leaving src2.
                alu_res = (src2 >> shamt) | (src2 << (WIDTH - int'(shamt)));
                upd_z   = 1'b1;
            end
            OP_PADDSB: alu_res = padd_res;
            OP_LLB:    alu_res = {src2[WIDTH-1:HW], src1[HW-1:0]};
            OP_LHB:    alu_res = {src1[HW-1:0], src2[HW-1:0]};
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mul_op) begin
                    state_d = ST_MUL_RUN;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = alu_res;
                    if (upd_zvn) begin
                        flags_d[FLAG_Z] = (alu_res == '0);
                        flags_d[FLAG_V] = alu_v;
                        flags_d[FLAG_N] = alu_res[WIDTH-1];
                    end else if (upd_z) begin
                        flags_d[FLAG_Z] = (alu_res == '0);
                    end
                end
            end
            ST_MUL_RUN: begin
                if (mul_done) begin
                    state_d         = ST_IDLE;
                    out_valid_d     = 1'b1;
                    result_d        = mul_res;
                    flags_d[FLAG_Z] = (mul_res == '0);
                    flags_d[FLAG_V] = ~mul_fits;
                    flags_d[FLAG_N] = mul_res[WIDTH-1];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            flags_q     <= 3'b000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign flags     = flags_q;
    assign out_valid = out_valid_q;
    assign busy      = ~in_ready;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle (WIDTH 16, LANE 4)
module tb_alu_multicycle;

    localparam int W = 16;

    typedef struct {
        int          cyc;
        logic [15:0] res;
        logic [2:0]  flg;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] src1;
    logic [15:0] src2;
    logic        out_valid;
    logic [15:0] result;
    logic [2:0]  flags;
    logic        busy;

    int          ncmp = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          mul_lo = 1;
    int          mul_hi = 0;
    logic [2:0]  m_flags = 3'b000;
    logic [2:0]  cur_flags = 3'b000;
    exp_t        q[$];
    exp_t        ce;
    bit          exp_busy;

    alu_multicycle #(
        .WIDTH (16),
        .LANE  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        ncmp++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] sat16(input longint s, output bit v);
        v = 1'b0;
        if (s > 32767) begin
            v = 1'b1;
            return 16'h7fff;
        end
        if (s < -32768) begin
            v = 1'b1;
            return 16'h8000;
        end
        return 16'(s);
    endfunction

    // Reference behaviour from the opcode rules; also advances the model flags.
    function automatic void model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output bit m);
        int     sa;
        int     sb;
        int     s;
        longint p;
        bit     v;
        sa = $signed(a);
        sb = $signed(b);
        m  = 1'b0;
        r  = 16'h0000;
        case (o)
            4'd0: begin
                r = sat16(longint'(sa + sb), v);
                m_flags = {(r == 16'h0), v, r[15]};
            end
            4'd1: begin
                r = sat16(longint'(sa - sb), v);
                m_flags = {(r == 16'h0), v, r[15]};
            end
            4'd2: begin
                r = a ^ b;
                m_flags[2] = (r == 16'h0);
            end
            4'd3: begin
                s = int'($signed(a[15:8])) + int'($signed(a[7:0]))
                  + int'($signed(b[15:8])) + int'($signed(b[7:0]));
                r = 16'(s);
            end
            4'd4: begin
                r = b << a[3:0];
                m_flags[2] = (r == 16'h0);
            end
            4'd5: begin
                r = 16'(sb >>> a[3:0]);
                m_flags[2] = (r == 16'h0);
            end
            4'd6: begin
                r = b;
                for (int i = 0; i < int'(a[3:0]); i++) r = {r[0], r[15:1]};
                m_flags[2] = (r == 16'h0);
            end
            4'd7: begin
                for (int i = 0; i < 4; i++) begin
                    s = int'($signed(a[i*4 +: 4])) + int'($signed(b[i*4 +: 4]));
                    if (s > 7) s = 7;
                    if (s < -8) s = -8;
                    r[i*4 +: 4] = 4'(s);
                end
            end
            4'd8: r = {b[15:8], a[7:0]};
            4'd9: r = {a[7:0], b[7:0]};
`ifdef ALU_MUL_EN
            4'd10: begin
                m = 1'b1;
                p = longint'(sa) * longint'(sb);
                r = sat16(p, v);
                m_flags = {(r == 16'h0), v, r[15]};
            end
`endif
            default: r = 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h7fff;
            2: return 16'h8000;
            3: return 16'hffff;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [15:0] r;
        bit          m;
        int          g;
        g = 0;
        while (in_ready !== 1'b1 && g < 64) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 64) chk("ready_timeout", in_ready, 1);
        op       = o;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        model(o, a, b, r, m);
        e.cyc = cyc + 1 + (m ? W : 0);
        e.res = r;
        e.flg = m_flags;
        q.push_back(e);
        if (m) begin
            mul_lo = cyc + 1;
            mul_hi = cyc + W;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycle-by-cycle compare against the model queue and expected ready window.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    ce = q.pop_front();
                    chk("latency", cyc, ce.cyc);
                    chk("result", result, ce.res);
                    cur_flags = ce.flg;
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                chk("missing_out_valid", out_valid, 1);
                void'(q.pop_front());
            end
            chk("flags", flags, cur_flags);
            exp_busy = (cyc >= mul_lo) && (cyc <= mul_hi);
            chk("in_ready", in_ready, !exp_busy);
            chk("busy", busy, exp_busy);
        end
    end

    initial begin
        int g;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = 4'd0;
        src1     = 16'h0;
        src2     = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 16'h0000);
        chk("rst_flags", flags, 3'b000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(4'd0, 16'h7fff, 16'h0001);
        chk("add_sat_valid", out_valid, 1);
        chk("add_sat_result", result, 16'h7fff);
        chk("add_sat_flags", flags, 3'b010);

        issue(4'd1, 16'h1234, 16'h1234);
        chk("sub_zero_result", result, 16'h0000);
        chk("sub_zero_flags", flags, 3'b100);
        issue(4'd8, 16'h00ab, 16'hff00);
        chk("llb_result", result, 16'hffab);
        chk("llb_flags", flags, 3'b100);

        issue(4'd7, 16'h1234, 16'h7821);
        chk("paddsb_result", result, 16'h7a55);
        chk("paddsb_flags", flags, 3'b100);

`ifdef ALU_MUL_EN
        issue(4'd10, 16'hfffd, 16'h0005);
        repeat (W - 1) @(posedge clk);
        #1;
        chk("mul_early_valid", out_valid, 0);
        chk("mul_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        chk("mul_valid", out_valid, 1);
        chk("mul_result", result, 16'hfff1);
        chk("mul_flags", flags, 3'b001);
        chk("mul_ready_back", in_ready, 1);

        issue(4'd10, 16'h0100, 16'h0100);
        repeat (W) @(posedge clk);
        #1;
        chk("mul_sat_result", result, 16'h7fff);
        chk("mul_sat_flags", flags, 3'b010);
`else
        issue(4'd10, 16'h0003, 16'h0005);
        chk("op10_valid", out_valid, 1);
        chk("op10_result", result, 16'h0000);
        chk("op10_flags", flags, 3'b100);
        chk("op10_ready", in_ready, 1);
`endif

        issue(4'd0, 16'h7fff, 16'h0001);
        issue(4'd10, 16'h0003, 16'h0004);
        repeat (4) @(posedge clk);
        #1;
        rst_n     = 1'b0;
        q.delete();
        m_flags   = 3'b000;
        cur_flags = 3'b000;
        mul_lo    = 1;
        mul_hi    = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_flags", flags, 3'b000);
        chk("abort_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 16'h0000);
        repeat (20) @(posedge clk);
        #1;

        issue(4'd1, 16'h8000, 16'h0001);
        chk("sub_neg_sat_flags", flags, 3'b011);
        issue(4'd6, 16'h0001, 16'h0001);
        chk("ror_result", result, 16'h8000);
        chk("ror_flags", flags, 3'b011);
        issue(4'd2, 16'haaaa, 16'haaaa);
        chk("xor_result", result, 16'h0000);
        chk("xor_flags", flags, 3'b111);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            issue(4'($urandom_range(0, 15)), pick(), pick());
        end

        g = 0;
        while (q.size() > 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
